// File: rtl/bram_arbiter_if.sv
// Requester-side memory port: one request/grant handshake plus the read-return path.
// The requester drives through the master modport and the arbiter takes the slave modport.
interface bram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/bram_arbiter.sv
// Two-port round-robin arbiter sharing one single-port BRAM between instruction fetch
// (m0) and data load/store (m1). Grant is combinational on the live requests; only the
// priority pointer and the pending-read tag are registered.
module bram_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BRAM_AW = 10
) (
    input  logic               clk,
    input  logic               rst,
    bram_arbiter_if.slave      m0,
    bram_arbiter_if.slave      m1,
    output logic               bram_we,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [DATA_W-1:0]  bram_din,
    input  logic [DATA_W-1:0]  bram_dout
);

    logic r_prio;      // 0: port 0 wins a tie, 1: port 1 wins a tie
    logic r_rd_vld;    // a read was granted last cycle
    logic r_rd_port;   // which port that read belongs to

    logic w_gnt0;
    logic w_gnt1;
    logic w_prio_nxt;
    logic w_rd_vld_nxt;
    logic w_rd_port_nxt;

    // Byte-offset bits and bits above the BRAM depth are dropped; addresses wrap.
    logic w_unused_addr;
    assign w_unused_addr = ^{m0.addr[ADDR_W-1:BRAM_AW+2], m0.addr[1:0],
                             m1.addr[ADDR_W-1:BRAM_AW+2], m1.addr[1:0]};

    // Arbitration: a lone requester wins, ties go to the pointer; nothing granted in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst) begin
            if (m0.req && (!m1.req || !r_prio)) begin
                w_gnt0 = 1'b1;
            end else if (m1.req) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    // BRAM drive: port 1's fields only when it holds the grant, otherwise port 0's.
    always_comb begin
        bram_addr = m0.addr[BRAM_AW+1:2];
        bram_din  = m0.wdata;
        bram_we   = 1'b0;
        if (w_gnt1) begin
            bram_addr = m1.addr[BRAM_AW+1:2];
            bram_din  = m1.wdata;
            bram_we   = m1.we;
        end else if (w_gnt0) begin
            bram_we   = m0.we;
        end
    end

    // Next-state: pointer moves to the other port after a transfer; tag granted reads.
    always_comb begin
        w_prio_nxt    = r_prio;
        w_rd_vld_nxt  = (w_gnt0 && !m0.we) || (w_gnt1 && !m1.we);
        w_rd_port_nxt = w_gnt1;
        if (w_gnt0) begin
            w_prio_nxt = 1'b1;
        end else if (w_gnt1) begin
            w_prio_nxt = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio    <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_rd_port <= 1'b0;
        end else begin
            r_prio    <= w_prio_nxt;
            r_rd_vld  <= w_rd_vld_nxt;
            r_rd_port <= w_rd_port_nxt;
        end
    end

    // Outputs: grants straight through; read data shared, valid only for the tagged port.
    // A read granted just before reset still returns while rst is high.
    always_comb begin
        m0.gnt    = w_gnt0;
        m1.gnt    = w_gnt1;
        m0.rvalid = r_rd_vld && !r_rd_port;
        m1.rvalid = r_rd_vld && r_rd_port;
        m0.rdata  = bram_dout;
        m1.rdata  = bram_dout;
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a behavioural one-cycle-latency BRAM.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_bram_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int BRAM_AW = 10;

    logic               clk = 1'b0;
    logic               rst;
    logic               bram_we;
    logic [BRAM_AW-1:0] bram_addr;
    logic [DATA_W-1:0]  bram_din;
    logic [DATA_W-1:0]  bram_dout;
    logic [DATA_W-1:0]  mem [2**BRAM_AW];

    int n_total = 0;
    int n_bad   = 0;

    bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
    bram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

    bram_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .BRAM_AW (BRAM_AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    // Read-first single-port BRAM, data valid one cycle after the address.
    always @(posedge clk) begin
        if (bram_we) mem[bram_addr] <= bram_din;
        bram_dout <= mem[bram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge, then apply both requesters' inputs.
    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        @(posedge clk);
        #1;
        m0_if.req = r0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
        m1_if.req = r1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2**BRAM_AW; i++) mem[i] = '0;
        rst = 1'b1;
        m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0;
        m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0;

        // Reset held two cycles with both ports requesting.
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
            check("rst_gnt0", 32'(m0_if.gnt), 32'd0);
            check("rst_gnt1", 32'(m1_if.gnt), 32'd0);
            check("rst_we", 32'(bram_we), 32'd0);
            check("rst_rv0", 32'(m0_if.rvalid), 32'd0);
            check("rst_rv1", 32'(m1_if.rvalid), 32'd0);
        end

        // First grant after release goes to port 0.
        rst = 1'b0;
        #1;
        check("rel_gnt0", 32'(m0_if.gnt), 32'd1);
        check("rel_gnt1", 32'(m1_if.gnt), 32'd0);

        // m0 writes DEADBEEF to 0x10; the read from release returns now.
        drive(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rel_rv0", 32'(m0_if.rvalid), 32'd1);
        check("rel_rv1", 32'(m1_if.rvalid), 32'd0);
        check("wr10_gnt0", 32'(m0_if.gnt), 32'd1);
        check("wr10_we", 32'(bram_we), 32'd1);
        check("wr10_addr", 32'(bram_addr), 32'd4);
        check("wr10_din", bram_din, 32'hDEADBEEF);

        // m0 reads 0x10.
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd10_gnt0", 32'(m0_if.gnt), 32'd1);
        check("rd10_addr", 32'(bram_addr), 32'd4);
        check("rd10_we", 32'(bram_we), 32'd0);
        check("wr10_norv", 32'(m0_if.rvalid), 32'd0);

        // m0 writes 0BADF00D to 0x4; read data for 0x10 returns.
        drive(1'b1, 1'b1, 32'h4, 32'h0BADF00D, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd10_rv0", 32'(m0_if.rvalid), 32'd1);
        check("rd10_data", m0_if.rdata, 32'hDEADBEEF);
        check("rd10_rv1", 32'(m1_if.rvalid), 32'd0);
        check("wr04_addr", 32'(bram_addr), 32'd1);
        check("wr04_we", 32'(bram_we), 32'd1);

        // m1 writes 12345678 to 0x1003, which wraps to word 0.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h1003, 32'h12345678);
        check("wrap_gnt1", 32'(m1_if.gnt), 32'd1);
        check("wrap_gnt0", 32'(m0_if.gnt), 32'd0);
        check("wrap_addr", 32'(bram_addr), 32'd0);
        check("wrap_we", 32'(bram_we), 32'd1);
        check("wrap_din", bram_din, 32'h12345678);
        check("wrap_norv", 32'(m0_if.rvalid), 32'd0);

        // m0 reads 0x0000.
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rd00_gnt0", 32'(m0_if.gnt), 32'd1);
        check("rd00_addr", 32'(bram_addr), 32'd0);
        check("rd00_we", 32'(bram_we), 32'd0);

        // m1 writes A5A5A5A5 to 0x20; word 0 read returns to m0.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5);
        check("rd00_rv0", 32'(m0_if.rvalid), 32'd1);
        check("rd00_data", m0_if.rdata, 32'h12345678);
        check("raw_wgnt1", 32'(m1_if.gnt), 32'd1);
        check("raw_waddr", 32'(bram_addr), 32'd8);
        check("raw_we", 32'(bram_we), 32'd1);

        // m1 reads 0x20 back-to-back; no rvalid for the write.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        check("raw_rgnt1", 32'(m1_if.gnt), 32'd1);
        check("raw_raddr", 32'(bram_addr), 32'd8);
        check("raw_norv1", 32'(m1_if.rvalid), 32'd0);

        // Contention: both read for 4 cycles, pointer is 0, so grants go 0,1,0,1.
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
            check("cont_gnt0", 32'(m0_if.gnt), (c % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_gnt1", 32'(m1_if.gnt), (c % 2 == 1) ? 32'd1 : 32'd0);
            check("cont_addr", 32'(bram_addr), (c % 2 == 0) ? 32'd0 : 32'd1);
            // Return from previous cycle: c=0 is the 0x20 read, then alternating.
            check("cont_rv0", 32'(m0_if.rvalid), (c % 2 == 1) ? 32'd1 : 32'd0);
            check("cont_rv1", 32'(m1_if.rvalid), (c % 2 == 0) ? 32'd1 : 32'd0);
            if (c == 0)          check("cont_data", m1_if.rdata, 32'hA5A5A5A5);
            else if (c % 2 == 1) check("cont_data", m0_if.rdata, 32'h12345678);
            else                 check("cont_data", m1_if.rdata, 32'h0BADF00D);
        end

        // m0 reads 0x10, then reset rises the next cycle.
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("last_rv1", 32'(m1_if.rvalid), 32'd1);
        check("last_data", m1_if.rdata, 32'h0BADF00D);
        check("mid_gnt0", 32'(m0_if.gnt), 32'd1);

        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        #1;
        check("mid_rv0", 32'(m0_if.rvalid), 32'd1);
        check("mid_data", m0_if.rdata, 32'hDEADBEEF);
        check("mid_gnt0_rst", 32'(m0_if.gnt), 32'd0);
        check("mid_we_rst", 32'(bram_we), 32'd0);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        check("post_rv0", 32'(m0_if.rvalid), 32'd0);
        check("post_rv1", 32'(m1_if.rvalid), 32'd0);

        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("post2_rv0", 32'(m0_if.rvalid), 32'd0);
        check("post2_rv1", 32'(m1_if.rvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port round-robin arbiter that shares one single-port 32-bit BRAM between two requesters: port 0 is instruction fetch, port 1 is data load/store. It sits between the core's memory-request ports and the block-RAM wrapper.
- Grants at most one access per cycle.
- Drives the BRAM word address, write enable and write data.
- Returns read data with a one-cycle valid strobe to the requester that issued the read.

## Interface
- ADDR_W, 32, requester byte-address width
- DATA_W, 32, data width
- BRAM_AW, 10, BRAM word-address width (depth = 2^BRAM_AW words)

- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset, synchronous, active-high
- m0_req  in  1  port 0 request
- m0_we  in  1  port 0 write (1) / read (0)
- m0_addr  in  ADDR_W  port 0 byte address
- m0_wdata  in  DATA_W  port 0 write data
- m0_gnt  out  1  port 0 granted this cycle (combinational)
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DATA_W  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1
- bram_we  out  1  BRAM write enable
- bram_addr  out  BRAM_AW  BRAM word address
- bram_din  out  DATA_W  BRAM write data
- bram_dout  in  DATA_W  BRAM read data; valid one cycle after the address is presented

## Operation
- **Handshake:** an access transfers in any cycle where mX_req=1 and mX_gnt=1.
  - The requester holds req/we/addr/wdata stable until it sees gnt.
  - The requester may drop req before grant; no access occurs.
- **Arbitration:** combinational over the current req inputs, using a 1-bit priority pointer `prio` (0 = port 0 preferred).
  - Only one req high: that port is granted.
  - Both high: port `prio` is granted.
  - Neither high: no grant.
  - gnt is forced to 0 while rst=1.
- **Pointer update:** registered, on a transfer only. After a grant to port X, `prio` becomes the other port. With no transfer, `prio` holds.
  - Result: under continuous contention grants alternate 0,1,0,1.
- **BRAM drive:**
  - bram_addr = granted port's addr[BRAM_AW+1:2].
  - Address bits [1:0] are ignored; there is no alignment check.
  - Bits above BRAM_AW+1 are ignored, so addresses wrap modulo the BRAM depth.
  - bram_din = granted port's wdata.
  - bram_we = granted port's we AND transfer.
  - With no grant: bram_we=0; bram_addr and bram_din hold port 0's values (don't-care).
- **Read return:** a granted read (we=0) sets a registered tag `rd_pend` (valid bit plus port id). In the next cycle:
  - mX_rvalid=1 only for the tagged port.
  - mX_rdata = bram_dout, routed combinationally to both ports.
  - rdata is meaningful only while rvalid=1.
- **Writes:** produce no rvalid. A write is complete at its grant edge.
- **Back-to-back transfers:** a new grant may occur in the same cycle as a pending rvalid, giving full throughput of one access per cycle.
- **Read-after-write:** a write granted in cycle t followed by a read of the same word granted in t+1 returns the new data.

## Timing
- **Reset values:** prio=0, rd_pend valid=0, m0_rvalid=m1_rvalid=0, m0_gnt=m1_gnt=0, bram_we=0.
- **Reset mid-operation:** a read granted in the cycle before rst rises still produces its rvalid in the cycle rst is high. The pending tag is cleared at the rst edge, so no rvalid is issued one cycle after rst deasserts.
- **Grant latency:** 0 cycles when uncontended (gnt in the same cycle as req). At most 1 extra transfer cycle under contention; no starvation.
- **Read latency:** rvalid exactly 1 cycle after the grant cycle.
- **Critical path:** req -> gnt -> bram_we/bram_addr is combinational and must meet clk within the BRAM setup time. There is no internal registering of the request path.
- **Simultaneous events:** both ports request with prio=0 -> port 0 is granted and prio becomes 1. Port 1 stays pending and is granted next cycle if it still requests.

## Test plan
- **Reset:** hold rst 2 cycles with both req=1 -> gnt=0, bram_we=0, rvalid=0 throughout. After release, first grant goes to port 0.
- **Single port read:** m0 writes 0xDEADBEEF to addr 0x10, then reads 0x10 -> bram_addr=4 on both grants. m0_rvalid=1 one cycle after the read grant with m0_rdata=0xDEADBEEF. m1_rvalid stays 0.
- **Contention:** m0 and m1 both hold read requests for 4 cycles (addrs 0x0 and 0x4) -> grants 0,1,0,1. rvalid alternates port 0/port 1 one cycle later, each with the matching word.
- **Wrap and alignment:** m1 writes 0x12345678 to byte addr 0x1003, then m0 reads 0x0000 -> bram_addr=0 for both. m0_rdata=0x12345678.
- **Read-after-write, back-to-back:** cycle t m1 writes 0xA5A5A5A5 to 0x20; cycle t+1 m1 reads 0x20 -> rvalid at t+2 with 0xA5A5A5A5. No rvalid at t+1.
- **Reset mid-read:** grant an m0 read in cycle t, assert rst in t+1 -> m0_rvalid=1 in t+1, then 0 in t+2 and every cycle after, until a new read is granted.
